// File: rtl/tlb_ctrl_pkg.sv
// Shared types and address helpers for the TLB miss controller.
// Covers the controller state encoding, the page geometry and PTE / physical-address arithmetic.
package tlb_ctrl_pkg;

  localparam int unsigned PAGE_BITS = 10;
  localparam int unsigned TLB_IDX_W = 4;
  localparam int unsigned XLEN      = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CHECK,
    ST_WALK,
    ST_FILL,
    ST_RESP
  } state_e;

  // Byte address of the 4-byte PTE indexed by the virtual page number.
  function automatic logic [XLEN-1:0] pte_addr(input logic [XLEN-1:0] base,
                                               input logic [XLEN-1:0] vaddr,
                                               input int unsigned     page_bits);
    return base + ((vaddr >> page_bits) << 2);
  endfunction

  // Physical page number placed above the untranslated page offset.
  function automatic logic [XLEN-1:0] compose_paddr(input logic [XLEN-1:0] ppn,
                                                    input logic [XLEN-1:0] vaddr,
                                                    input int unsigned     page_bits);
    logic [XLEN-1:0] mask;
    mask = (XLEN'(1) << page_bits) - XLEN'(1);
    return (ppn << page_bits) | (vaddr & mask);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hit/miss/fault debug statistics.
// Stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tlb_miss_controller.sv
// Per-request TLB sequencer: lookup, hit check, page-table walk on miss, TLB fill and response.
// All outputs are registered; one request is in flight at a time.
module tlb_miss_controller
  import tlb_ctrl_pkg::*;
#(
  parameter int unsigned PAGE_BITS     = tlb_ctrl_pkg::PAGE_BITS,
  parameter int unsigned PTE_VALID_BIT = 0,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_vaddr,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_paddr,
  output logic             resp_fault,
  input  logic [31:0]      ptbr,
  output logic             tlb_write_enable,
  output logic [31:0]      tlb_virt_addr,
  output logic [31:0]      tlb_phys_page,
  input  logic [31:0]      tlb_phys_page_out,
  input  logic             tlb_hit,
  output logic             mem_read_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ready,
  input  logic [31:0]      mem_data,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] fault_count
);

  state_e      state_q, state_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic [31:0] ptbr_q, ptbr_d;

  logic        req_ready_d;
  logic        resp_valid_d;
  logic [31:0] resp_paddr_d;
  logic        resp_fault_d;
  logic        tlb_write_enable_d;
  logic [31:0] tlb_virt_addr_d;
  logic [31:0] tlb_phys_page_d;
  logic        mem_read_req_d;
  logic [31:0] mem_addr_d;

  logic        hit_inc_c;
  logic        miss_inc_c;
  logic        fault_inc_c;

  // State and output registers; reset wins over everything, dropping any walk in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      vaddr_q          <= '0;
      ptbr_q           <= '0;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_paddr       <= '0;
      resp_fault       <= 1'b0;
      tlb_write_enable <= 1'b0;
      tlb_virt_addr    <= '0;
      tlb_phys_page    <= '0;
      mem_read_req     <= 1'b0;
      mem_addr         <= '0;
    end else begin
      state_q          <= state_d;
      vaddr_q          <= vaddr_d;
      ptbr_q           <= ptbr_d;
      req_ready        <= req_ready_d;
      resp_valid       <= resp_valid_d;
      resp_paddr       <= resp_paddr_d;
      resp_fault       <= resp_fault_d;
      tlb_write_enable <= tlb_write_enable_d;
      tlb_virt_addr    <= tlb_virt_addr_d;
      tlb_phys_page    <= tlb_phys_page_d;
      mem_read_req     <= mem_read_req_d;
      mem_addr         <= mem_addr_d;
    end
  end

  // Next state plus next value of every registered output, so outputs line up with their state.
  always_comb begin
    state_d            = state_q;
    vaddr_d            = vaddr_q;
    ptbr_d             = ptbr_q;
    req_ready_d        = req_ready;
    resp_valid_d       = resp_valid;
    resp_paddr_d       = resp_paddr;
    resp_fault_d       = resp_fault;
    tlb_write_enable_d = 1'b0;
    tlb_virt_addr_d    = tlb_virt_addr;
    tlb_phys_page_d    = tlb_phys_page;
    mem_read_req_d     = 1'b0;
    mem_addr_d         = mem_addr;
    hit_inc_c          = 1'b0;
    miss_inc_c         = 1'b0;
    fault_inc_c        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          vaddr_d         = req_vaddr;
          ptbr_d          = ptbr;
          req_ready_d     = 1'b0;
          resp_paddr_d    = '0;
          resp_fault_d    = 1'b0;
          tlb_virt_addr_d = req_vaddr;
          state_d         = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        state_d = ST_CHECK;
      end

      ST_CHECK: begin
        if (tlb_hit) begin
          resp_paddr_d = compose_paddr(tlb_phys_page_out, vaddr_q, PAGE_BITS);
          resp_valid_d = 1'b1;
          hit_inc_c    = 1'b1;
          state_d      = ST_RESP;
        end else begin
          mem_read_req_d = 1'b1;
          mem_addr_d     = pte_addr(ptbr_q, vaddr_q, PAGE_BITS);
          miss_inc_c     = 1'b1;
          state_d        = ST_WALK;
        end
      end

      ST_WALK: begin
        mem_read_req_d = 1'b1;
        if (mem_ready) begin
          mem_read_req_d = 1'b0;
          if (mem_data[PTE_VALID_BIT]) begin
            tlb_write_enable_d = 1'b1;
            tlb_virt_addr_d    = vaddr_q;
            tlb_phys_page_d    = mem_data >> PAGE_BITS;
            resp_paddr_d       = compose_paddr(mem_data >> PAGE_BITS, vaddr_q, PAGE_BITS);
            state_d            = ST_FILL;
          end else begin
            resp_fault_d = 1'b1;
            resp_paddr_d = '0;
            resp_valid_d = 1'b1;
            fault_inc_c  = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end

      ST_FILL: begin
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end

      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (hit_inc_c),
    .count (hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (miss_inc_c),
    .count (miss_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fault_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (fault_inc_c),
    .count (fault_count)
  );

endmodule

// File: tb/tb_tlb_miss_controller.sv
// Scoreboard bench for tlb_miss_controller with a behavioural 16-entry TLB and a PTE memory responder.
module tb_tlb_miss_controller;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_paddr;
  logic        resp_fault;
  logic [31:0] ptbr;
  logic        tlb_write_enable;
  logic [31:0] tlb_virt_addr;
  logic [31:0] tlb_phys_page;
  logic [31:0] tlb_phys_page_out;
  logic        tlb_hit;
  logic        mem_read_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [15:0] fault_count;

  typedef struct {
    logic [31:0] paddr;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  // Memory responder controls
  logic        mem_auto  = 1'b0;
  logic        mem_stray = 1'b0;
  int          mem_delay = 0;
  logic [31:0] mem_pte   = '0;
  int          wait_cnt  = 0;

  // Expected walk/fill payloads and event counts seen by the monitor
  logic [31:0] exp_mem_addr  = '0;
  logic [31:0] exp_fill_va   = '0;
  logic [31:0] exp_fill_page = '0;
  int          walks = 0;
  int          fills = 0;

  logic        tlb_flush;
  logic        tlb_v   [16];
  logic [17:0] tlb_tag [16];
  logic [31:0] tlb_ppn [16];

  tlb_miss_controller dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_vaddr         (req_vaddr),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_paddr        (resp_paddr),
    .resp_fault        (resp_fault),
    .ptbr              (ptbr),
    .tlb_write_enable  (tlb_write_enable),
    .tlb_virt_addr     (tlb_virt_addr),
    .tlb_phys_page     (tlb_phys_page),
    .tlb_phys_page_out (tlb_phys_page_out),
    .tlb_hit           (tlb_hit),
    .mem_read_req      (mem_read_req),
    .mem_addr          (mem_addr),
    .mem_ready         (mem_ready),
    .mem_data          (mem_data),
    .hit_count         (hit_count),
    .miss_count        (miss_count),
    .fault_count       (fault_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Direct-mapped TLB, registered lookup, index vaddr[13:10], tag vaddr[31:14]
  always @(posedge clk) begin
    tlb_hit           <= tlb_v[tlb_virt_addr[13:10]] && (tlb_tag[tlb_virt_addr[13:10]] == tlb_virt_addr[31:14]);
    tlb_phys_page_out <= tlb_ppn[tlb_virt_addr[13:10]];
    if (tlb_flush) begin
      for (int i = 0; i < 16; i++) begin
        tlb_v[i]   <= 1'b0;
        tlb_tag[i] <= '0;
        tlb_ppn[i] <= '0;
      end
    end else if (tlb_write_enable) begin
      tlb_v[tlb_virt_addr[13:10]]   <= 1'b1;
      tlb_tag[tlb_virt_addr[13:10]] <= tlb_virt_addr[31:14];
      tlb_ppn[tlb_virt_addr[13:10]] <= tlb_phys_page;
    end
  end

  // PTE memory: answers mem_delay cycles into a walk, or replays a stray pulse when disabled
  always begin
    @(posedge clk);
    #1;
    if (mem_auto) begin
      mem_ready = 1'b0;
      if (mem_read_req) begin
        if (wait_cnt == mem_delay) begin
          mem_ready = 1'b1;
          mem_data  = mem_pte;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end else begin
      mem_ready = mem_stray;
      wait_cnt  = 0;
    end
  end

  int          cyc         = 0;
  int          accept_cyc  = 0;
  logic        resp_seen   = 1'b0;
  logic        walk_active = 1'b0;
  logic [31:0] held_addr   = '0;
  logic [31:0] held_paddr  = '0;
  logic        held_fault  = 1'b0;

  // Monitor: walk address stability, fill payloads, response latency/stability, scoreboard pop
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      resp_seen   = 1'b0;
      walk_active = 1'b0;
    end else begin
      if (req_valid && req_ready) accept_cyc = cyc;
      if (mem_read_req) begin
        if (!walk_active) begin
          walk_active = 1'b1;
          walks++;
          held_addr = mem_addr;
          chk("mem_addr", mem_addr, exp_mem_addr);
        end else begin
          chk("mem_addr_hold", mem_addr, held_addr);
        end
      end else begin
        walk_active = 1'b0;
      end
      if (tlb_write_enable) begin
        fills++;
        chk("fill_virt_addr", tlb_virt_addr, exp_fill_va);
        chk("fill_phys_page", tlb_phys_page, exp_fill_page);
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          if (!resp_seen) begin
            resp_seen  = 1'b1;
            held_paddr = resp_paddr;
            held_fault = resp_fault;
            if (sb[0].lat != 0) chk("latency", 32'(cyc - accept_cyc), 32'(sb[0].lat));
          end else begin
            chk("resp_paddr_hold", resp_paddr, held_paddr);
            chk("resp_fault_hold", 32'(resp_fault), 32'(held_fault));
          end
          if (resp_ready) begin
            e = sb.pop_front();
            chk("resp_paddr", resp_paddr, e.paddr);
            chk("resp_fault", 32'(resp_fault), 32'(e.fault));
            resp_seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] va, input logic [31:0] base,
                      input logic [31:0] exp_pa, input logic exp_flt, input int lat);
    exp_t e;
    int   n;
    n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    if (!req_ready) chk("send_timeout", 32'(req_ready), 32'd1);
    e.paddr = exp_pa;
    e.fault = exp_flt;
    e.lat   = lat;
    sb.push_back(e);
    req_valid = 1'b1;
    req_vaddr = va;
    ptbr      = base;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 300) begin
      tick();
      n++;
    end
    if (sb.size() != 0 || !req_ready) chk("resp_timeout", 32'(sb.size()), 32'd0);
  endtask

  int w0, f0;

  initial begin
    reset      = 1'b1;
    tlb_flush  = 1'b1;
    req_valid  = 1'b0;
    req_vaddr  = '0;
    ptbr       = '0;
    resp_ready = 1'b1;
    mem_ready  = 1'b0;
    mem_data   = '0;
    repeat (3) tick();
    reset     = 1'b0;
    tlb_flush = 1'b0;

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_paddr", resp_paddr, 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_tlb_we", 32'(tlb_write_enable), 32'd0);
    chk("rst_mem_req", 32'(mem_read_req), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
    chk("rst_fault_count", 32'(fault_count), 32'd0);

    // Cold miss with a valid PTE, memory answers in the first walk cycle
    mem_auto      = 1'b1;
    mem_delay     = 0;
    mem_pte       = 32'h0004_5401;
    exp_mem_addr  = 32'h0000_102C;
    exp_fill_va   = 32'h0000_2C37;
    exp_fill_page = 32'h0000_0115;
    send(32'h0000_2C37, 32'h0000_1000, 32'h0004_5437, 1'b0, 5);
    wait_done();
    chk("cold_miss_count", 32'(miss_count), 32'd1);
    chk("cold_fill_count", 32'(fills), 32'd1);
    chk("cold_walk_count", 32'(walks), 32'd1);

    // Same address now hits in the TLB: no walk, no fill
    w0 = walks;
    f0 = fills;
    send(32'h0000_2C37, 32'h0000_1000, 32'h0004_5437, 1'b0, 3);
    wait_done();
    chk("hit_count", 32'(hit_count), 32'd1);
    chk("hit_no_walk", 32'(walks), 32'(w0));
    chk("hit_no_fill", 32'(fills), 32'(f0));

    // Invalid PTE produces a fault with a zero address and no fill
    mem_pte      = 32'h0004_5400;
    exp_mem_addr = 32'h0000_1050;
    f0 = fills;
    send(32'h0000_5123, 32'h0000_1000, 32'h0000_0000, 1'b1, 4);
    wait_done();
    chk("fault_count", 32'(fault_count), 32'd1);
    chk("fault_miss_count", 32'(miss_count), 32'd2);
    chk("fault_no_fill", 32'(fills), 32'(f0));

    // Memory stall of 7 cycles and 4 cycles of response backpressure
    mem_delay     = 7;
    mem_pte       = 32'h0012_3401;
    exp_mem_addr  = 32'h0000_2098;
    exp_fill_va   = 32'h0000_9ABC;
    exp_fill_page = 32'h0000_048D;
    resp_ready    = 1'b0;
    send(32'h0000_9ABC, 32'h0000_2000, 32'h0012_36BC, 1'b0, 12);
    for (int n = 0; n < 100 && !resp_valid; n++) begin
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    chk("stall_resp_valid", 32'(resp_valid), 32'd1);
    for (int n = 0; n < 4; n++) begin
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      tick();
    end
    resp_ready = 1'b1;
    wait_done();
    chk("stall_miss_count", 32'(miss_count), 32'd3);

    // Reset in the middle of a walk, then a stray mem_ready in IDLE
    mem_auto     = 1'b0;
    exp_mem_addr = 32'h0000_10F0;
    send(32'h0000_F000, 32'h0000_1000, 32'h0000_0000, 1'b0, 0);
    for (int n = 0; n < 20 && !mem_read_req; n++) tick();
    chk("walk_started", 32'(mem_read_req), 32'd1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    chk("mid_rst_mem_req", 32'(mem_read_req), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_hits", 32'(hit_count), 32'd0);
    chk("mid_rst_misses", 32'(miss_count), 32'd0);
    chk("mid_rst_faults", 32'(fault_count), 32'd0);
    f0 = fills;
    @(negedge clk);
    mem_stray = 1'b1;
    @(negedge clk);
    mem_stray = 1'b0;
    tick();
    tick();
    chk("stray_req_ready", 32'(req_ready), 32'd1);
    chk("stray_mem_req", 32'(mem_read_req), 32'd0);
    chk("stray_resp_valid", 32'(resp_valid), 32'd0);
    chk("stray_no_fill", 32'(fills), 32'(f0));
    chk("stray_faults", 32'(fault_count), 32'd0);
    chk("stray_misses", 32'(miss_count), 32'd0);
    mem_auto = 1'b1;

    // Hit counter saturation from 0xFFFE
    force dut.u_hit_cnt.count_q = 16'hFFFE;
    tick();
    release dut.u_hit_cnt.count_q;
    tick();
    chk("sat_preload", 32'(hit_count), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      send(32'h0000_2C37, 32'h0000_1000, 32'h0004_5437, 1'b0, 3);
      wait_done();
      chk("sat_hit_count", 32'(hit_count), 32'h0000_FFFF);
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
